// File: rtl/tmr_ureg_pkg.sv
// Shared types and constants for the TMR universal shift register family.
package tmr_ureg_pkg;

  // Operating mode of the universal register.
  typedef enum logic [1:0] {
    MODE_SISO = 2'b00,
    MODE_SIPO = 2'b01,
    MODE_PISO = 2'b10,
    MODE_PIPO = 2'b11
  } ureg_mode_t;

  // Shift direction: toward MSB (serial_in enters bit 0) or toward LSB.
  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/tmr_universal_shift_register_if.sv
// Control/data bundle of the TMR universal shift register.
// There is no valid/ready handshake: every rising clock edge is a transaction.
// The master drives the controls (enable, mode, dir, load, serial/parallel
// data, fault injection, err_clr), which are sampled at every edge. The slave
// presents serial_out/parallel_out combinationally from the voted contents,
// and err_replica/err_count as registered status.
interface tmr_universal_shift_register_if
  import tmr_ureg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();
  logic             enable;
  ureg_mode_t       mode;
  logic             dir;
  logic             load;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic [2:0]       inj_sel;
  logic [WIDTH-1:0] inj_mask;
  logic             err_clr;
  logic             serial_out;
  logic [WIDTH-1:0] parallel_out;
  logic [2:0]       err_replica;
  logic [CNT_W-1:0] err_count;

  modport master (
    output enable, mode, dir, load, serial_in, parallel_in,
    output inj_sel, inj_mask, err_clr,
    input  serial_out, parallel_out, err_replica, err_count
  );

  modport slave (
    input  enable, mode, dir, load, serial_in, parallel_in,
    input  inj_sel, inj_mask, err_clr,
    output serial_out, parallel_out, err_replica, err_count
  );
endinterface

// File: rtl/tmr_voter.sv
// Bitwise 2-of-3 majority voter with per-input disagreement flags.
module tmr_voter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted,
  output logic [2:0]       mis
);
  // Majority per bit; mis[i] marks the input that differs from the vote.
  always_comb begin
    voted  = (a & b) | (a & c) | (b & c);
    mis[0] = (a != voted);
    mis[1] = (b != voted);
    mis[2] = (c != voted);
  end
endmodule

// File: rtl/tmr_universal_shift_register.sv
// WIDTH-bit universal register (SISO/SIPO/PISO/PIPO) with triplicated
// storage, majority voting, scrubbing on every edge, fault injection and
// mismatch reporting.
module tmr_universal_shift_register
  import tmr_ureg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  tmr_universal_shift_register_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] rep [3];
  logic [WIDTH-1:0] voted;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt;
  logic [2:0]       mis;
  logic [2:0]       err_replica_q;
  logic [CNT_W-1:0] err_count_q;

  tmr_voter #(.WIDTH(WIDTH)) u_voter (
    .a     (rep[0]),
    .b     (rep[1]),
    .c     (rep[2]),
    .voted (voted),
    .mis   (mis)
  );

  // Next value derives from the vote only, so every edge also scrubs.
  always_comb begin
    if (bus.dir == DIR_MSB) shifted = {voted[WIDTH-2:0], bus.serial_in};
    else                    shifted = {bus.serial_in, voted[WIDTH-1:1]};
    nxt = voted;
    if (bus.enable) begin
      case (bus.mode)
        MODE_SISO, MODE_SIPO: nxt = shifted;
        MODE_PISO:            nxt = bus.load ? bus.parallel_in : shifted;
        MODE_PIPO:            nxt = bus.load ? bus.parallel_in : voted;
        default:              nxt = voted;
      endcase
    end
  end

  // Replica write with optional XOR upset on the selected replicas.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) rep[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        rep[i] <= nxt ^ (bus.inj_sel[i] ? bus.inj_mask : '0);
    end
  end

  // Mismatch snapshot and saturating error counter; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_replica_q <= '0;
      err_count_q   <= '0;
    end else begin
      err_replica_q <= mis;
      if (bus.err_clr)
        err_count_q <= '0;
      else if ((|mis) && (err_count_q != CNT_MAX))
        err_count_q <= err_count_q + 1'b1;
    end
  end

  // Output muxing: serial port in SISO/PISO, parallel port in SIPO/PIPO.
  always_comb begin
    bus.serial_out   = 1'b0;
    bus.parallel_out = '0;
    if (bus.mode == MODE_SISO || bus.mode == MODE_PISO)
      bus.serial_out = (bus.dir == DIR_MSB) ? voted[WIDTH-1] : voted[0];
    else
      bus.parallel_out = voted;
    bus.err_replica = err_replica_q;
    bus.err_count   = err_count_q;
  end
endmodule

// File: tb/tb_tmr_universal_shift_register.sv
// Scoreboard bench for tmr_universal_shift_register: directed scenarios
// followed by randomized traffic, checked against a replica-level model.
module tb_tmr_universal_shift_register;
  import tmr_ureg_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int EW    = W + 1 + 3 + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmr_universal_shift_register_if #(.WIDTH(W), .CNT_W(CNT_W)) bus ();

  tmr_universal_shift_register #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int tests  = 0;
  int errors = 0;

  logic [W-1:0] m_rep [3];
  logic [2:0]   m_err;
  int           m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] majority(input logic [W-1:0] a, b, c);
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) begin
      int votes;
      votes = int'(a[k]) + int'(b[k]) + int'(c[k]);
      v[k] = (votes >= 2);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_rep[i] = '0;
    m_err = '0;
    m_cnt = 0;
  endtask

  // ---------------- driver ----------------
  // Called right after a falling edge: applies inputs, predicts the state
  // after the coming rising edge, queues it, then waits for the next fall.
  task automatic step(input logic en, input logic [1:0] md, input logic d,
                      input logic ld, input logic si, input logic [W-1:0] pi,
                      input logic [2:0] isel, input logic [W-1:0] imask,
                      input logic clr);
    logic [W-1:0] v, n, nv, par;
    logic [2:0]   mis;
    logic         ser;
    bus.enable      = en;
    bus.mode        = ureg_mode_t'(md);
    bus.dir         = d;
    bus.load        = ld;
    bus.serial_in   = si;
    bus.parallel_in = pi;
    bus.inj_sel     = isel;
    bus.inj_mask    = imask;
    bus.err_clr     = clr;

    v = majority(m_rep[0], m_rep[1], m_rep[2]);
    for (int i = 0; i < 3; i++) mis[i] = (m_rep[i] != v);
    if (!en)                                n = v;
    else if ((md == 2'd2 || md == 2'd3) && ld) n = pi;
    else if (md == 2'd3)                     n = v;
    else if (d == 1'b0)                      n = W'((v << 1) | W'(si));
    else                                     n = (v >> 1) | (W'(si) << (W - 1));
    for (int i = 0; i < 3; i++) m_rep[i] = isel[i] ? (n ^ imask) : n;
    m_err = mis;
    if (clr)                        m_cnt = 0;
    else if (mis != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;

    nv  = majority(m_rep[0], m_rep[1], m_rep[2]);
    par = (md == 2'd1 || md == 2'd3) ? nv : '0;
    ser = (md == 2'd0 || md == 2'd2) ? (d ? nv[0] : nv[W-1]) : 1'b0;
    exp_q.push_back({par, ser, m_err, CNT_W'(m_cnt)});
    @(negedge clk);
  endtask

  task automatic idle_step(input logic [1:0] md, input logic d);
    step(1'b1, md, d, 1'b0, 1'b0, '0, 3'b000, '0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      chk("parallel_out", 32'(bus.parallel_out), 32'(e[EW-1 -: W]));
      chk("serial_out",   32'(bus.serial_out),   32'(e[CNT_W+3]));
      chk("err_replica",  32'(bus.err_replica),  32'(e[CNT_W+2 -: 3]));
      chk("err_count",    32'(bus.err_count),    32'(e[CNT_W-1:0]));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] bits;
    model_reset();
    bus.enable = 1'b0; bus.mode = MODE_PIPO; bus.dir = DIR_MSB; bus.load = 1'b0;
    bus.serial_in = 1'b0; bus.parallel_in = '0; bus.inj_sel = '0;
    bus.inj_mask = '0; bus.err_clr = 1'b0;
    #1;
    chk("reset parallel_out", 32'(bus.parallel_out), 32'h0);
    chk("reset err_replica",  32'(bus.err_replica),  32'h0);
    chk("reset err_count",    32'(bus.err_count),    32'h0);
    @(negedge clk);
    rst = 1'b0;

    // SISO dir=0: pattern 1,0,1,1,0,0,0,0 then zeros.
    bits = 8'b0000_1101;
    for (int i = 0; i < 12; i++)
      step(1'b1, 2'd0, DIR_MSB, 1'b0, (i < 8) ? bits[i] : 1'b0, '0, 3'b000, '0, 1'b0);
    chk("siso err_count", 32'(bus.err_count), 32'h0);

    // PIPO load 0xA5, hold, enable low in the middle.
    step(1'b1, 2'd3, DIR_MSB, 1'b1, 1'b0, 8'hA5, 3'b000, '0, 1'b0);
    step(1'b1, 2'd3, DIR_MSB, 1'b0, 1'b0, 8'h3C, 3'b000, '0, 1'b0);
    step(1'b0, 2'd3, DIR_MSB, 1'b1, 1'b0, 8'h3C, 3'b000, '0, 1'b0);
    step(1'b1, 2'd3, DIR_MSB, 1'b0, 1'b0, 8'h3C, 3'b000, '0, 1'b0);
    chk("pipo hold", 32'(bus.parallel_out), 32'hA5);

    // Single-replica upset is scrubbed.
    step(1'b1, 2'd3, DIR_MSB, 1'b0, 1'b0, '0, 3'b010, 8'h0F, 1'b0);
    idle_step(2'd3, DIR_MSB);
    chk("single upset err_replica", 32'(bus.err_replica), 32'h2);
    idle_step(2'd3, DIR_MSB);
    idle_step(2'd3, DIR_MSB);
    chk("single upset value", 32'(bus.parallel_out), 32'hA5);
    chk("single upset count", 32'(bus.err_count), 32'h1);

    // Double-replica upset outvotes the good copy.
    step(1'b1, 2'd3, DIR_MSB, 1'b0, 1'b0, '0, 3'b011, 8'h01, 1'b0);
    idle_step(2'd3, DIR_MSB);
    chk("double upset value", 32'(bus.parallel_out), 32'hA4);
    chk("double upset err_replica", 32'(bus.err_replica), 32'h4);
    idle_step(2'd3, DIR_MSB);

    // PISO dir=1: load 0x96, shift with a two-edge pause.
    step(1'b1, 2'd2, DIR_LSB, 1'b1, 1'b0, 8'h96, 3'b000, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i == 4) begin
        step(1'b0, 2'd2, DIR_LSB, 1'b0, 1'b1, '0, 3'b000, '0, 1'b0);
        step(1'b0, 2'd2, DIR_LSB, 1'b0, 1'b1, '0, 3'b000, '0, 1'b0);
      end
      idle_step(2'd2, DIR_LSB);
    end

    // Saturation with a fault every cycle, then clear alongside a fault.
    step(1'b1, 2'd1, DIR_MSB, 1'b0, 1'b1, '0, 3'b000, '0, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'd1, DIR_MSB, 1'b0, 1'b1, '0, 3'b001, 8'h80, 1'b0);
    chk("saturated count", 32'(bus.err_count), 32'h3);
    step(1'b1, 2'd1, DIR_MSB, 1'b0, 1'b1, '0, 3'b100, 8'h02, 1'b1);
    chk("clear beats increment", 32'(bus.err_count), 32'h0);

    // Asynchronous reset between edges in the middle of a shift.
    step(1'b1, 2'd1, DIR_MSB, 1'b0, 1'b1, '0, 3'b010, 8'h10, 1'b0);
    step(1'b1, 2'd1, DIR_MSB, 1'b0, 1'b1, '0, 3'b000, '0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst parallel_out", 32'(bus.parallel_out), 32'h0);
    chk("async rst err_replica",  32'(bus.err_replica),  32'h0);
    chk("async rst err_count",    32'(bus.err_count),    32'h0);
    bus.mode = MODE_SISO;
    #1;
    chk("async rst serial_out", 32'(bus.serial_out), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] isel;
      isel = ($urandom_range(0, 99) < 15) ? 3'($urandom_range(1, 7)) : 3'b000;
      step(($urandom_range(0, 99) < 80), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), W'($urandom), isel, W'($urandom),
           ($urandom_range(0, 99) < 10));
    end

    @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/tmr_universal_shift_register.md
Name: tmr_universal_shift_register

Overview:
Parametrised successor to the 4-bit TMR universal register, sitting in the same register-file/IO datapath slot. It provides a WIDTH-bit universal register with four modes: SISO, SIPO, PISO and PIPO.
- Shift direction is selectable.
- Storage is triplicated, with bitwise majority voting and continuous scrubbing.
- It adds a fault-injection port, per-replica mismatch reporting and a saturating error counter for radiation/fault campaigns.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  functional enable; 0 = hold (scrub only)
mode  in  2  00 SISO, 01 SIPO, 10 PISO, 11 PIPO
dir  in  1  0 = shift toward MSB (serial_in enters bit 0); 1 = toward LSB (serial_in enters bit WIDTH-1)
load  in  1  parallel load request (PISO/PIPO only)
serial_in  in  1  serial data input
parallel_in  in  WIDTH  parallel data input
inj_sel  in  3  one-hot-or-multi replica select for fault injection (bit i = replica i)
inj_mask  in  WIDTH  XOR mask applied to selected replicas
err_clr  in  1  synchronous clear of err_count
serial_out  out  1  serial output
parallel_out  out  WIDTH  parallel output
err_replica  out  3  registered: replicas that disagreed with the vote in the previous cycle
err_count  out  CNT_W  saturating count of cycles with any mismatch

Behaviour:
- Storage is replicas r0, r1 and r2, each WIDTH bits. voted = bitwise majority(r0, r1, r2). mis[i] = (ri != voted).
- Next value nxt is computed from voted only, never from an individual replica:
  - enable=0 -> nxt = voted; load is ignored.
  - SISO/SIPO, or PISO with load=0: shift. dir=0 gives {voted[W-2:0], serial_in}; dir=1 gives {serial_in, voted[W-1:1]}.
  - PISO or PIPO with load=1 -> nxt = parallel_in.
  - PIPO with load=0 -> nxt = voted.
- Every edge writes ri <= nxt ^ (inj_sel[i] ? inj_mask : 0).
  - Any single-replica upset is therefore corrected on the following edge, regardless of enable.
  - inj_sel=000 is normal operation.
- Outputs are combinational from voted:
  - serial_out = voted[W-1] if dir=0, else voted[0], in modes 00/10; 0 in modes 01/11.
  - parallel_out = voted in modes 01/11; 0 in modes 00/10.
- Latency:
  - A serial_in bit reaches serial_out after WIDTH enabled shift edges.
  - A parallel load is visible on parallel_out after 1 edge.
- Error reporting:
  - Each edge: err_replica <= mis.
  - err_count increments by 1 if |mis, saturating at 2^CNT_W-1.
  - err_clr=1 sets err_count to 0; clear wins over a simultaneous increment.
  - err_replica is valid the cycle after the corrupted cycle.
- A two-replica upset of the same bit is outvoted silently: the wrong value propagates and the single correct replica is flagged. This is a documented limitation, not detected.
- Mode, dir or enable changes take effect at the next edge. There is no mid-shift state machine, so switching mode mid-stream continues from the voted contents.
- Reset, asynchronous and at any time including mid-shift: r0=r1=r2=0, err_replica=0, err_count=0. Consequently serial_out=0 and parallel_out=0 immediately.

Decomposition:
- Package tmr_ureg_pkg holds:
  - typedef enum logic [1:0] ureg_mode_t, with values MODE_SISO, MODE_SIPO, MODE_PISO, MODE_PIPO
  - constants DIR_MSB=0 and DIR_LSB=1
- Sub-module tmr_voter, parameter WIDTH: inputs a, b, c; outputs voted and mis[2:0]. It is purely combinational and reused by other TMR blocks.
- Top level contains the replicas, next-value mux, injection XOR, counters and output muxing.

Test Plan:
1. SISO, dir=0, enable=1, WIDTH=8: shift 1,0,1,1,0,0,0,0, then zeros -> serial_out reproduces 1,0,1,1 on edges 8-11; err_count stays 0.
2. PIPO, load=1, parallel_in=0xA5 for one edge, then load=0 for 3 edges -> parallel_out=0xA5 from the first edge on. Toggling enable=0 mid-test changes nothing.
3. PIPO holding 0xA5, inj_sel=010, inj_mask=0x0F for one edge -> parallel_out stays 0xA5, err_replica=010 on the next cycle then 000, err_count=1. No further increments after scrub.
4. PIPO holding 0xA5, inj_sel=011, inj_mask=0x01 -> parallel_out becomes 0xA4, err_replica=100, err_count increments once.
5. PISO, dir=1, load 0x96 then shift 8 edges with serial_in=0 -> serial_out sequence 0,1,1,0,1,0,0,1. Then assert enable=0 for 2 edges mid-shift -> the sequence pauses without loss.
6. CNT_W=2, inject a fault every cycle for 5 cycles -> err_count saturates at 3. err_clr together with a fault -> err_count=0. Assert rst asynchronously mid-shift -> all outputs 0 immediately, without waiting for an edge.
